// File: rtl/dsp48a1_mac_ctrl.sv
// rtl/dsp48a1_mac_ctrl.sv - DSP48A1 multiply-accumulate dot-product sequencer
// Optional subtract mode (input sub) is built when DSP48A1_MAC_CTRL_SUB_EN is defined.
module dsp48a1_mac_ctrl #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OP_SKEW  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
`ifdef DSP48A1_MAC_CTRL_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      a_in,
  input  logic [17:0]      b_in,
  output logic [17:0]      dsp_A,
  output logic [17:0]      dsp_B,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_P,
  output logic [47:0]      result,
  output logic             result_valid,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_t           state_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [DW-1:0]    drn_q;
  logic             zero_q;
  logic [7:0]       tag_q [OP_SKEW];
  logic [17:0]      a_q, b_q;
  logic [7:0]       opm_q;
  logic             ce_q, rst_q, rdy_q, rv_q, busy_q;
  logic [47:0]      res_q;
  logic             sub_bit;
  logic             accept, last;
  logic [7:0]       tag_d;

`ifdef DSP48A1_MAC_CTRL_SUB_EN
  logic sub_q;
  assign sub_bit = sub_q;
`else
  assign sub_bit = 1'b0;
`endif

  assign accept = in_valid && rdy_q;
  assign last   = accept && (cnt_q == len_q - LEN_W'(1));

  // Every cycle in RUN/DRAIN is a slot: a pair, or a zero bubble that adds nothing.
  always_comb begin
    tag_d = 8'h00;
    if (accept)
      tag_d = (cnt_q == '0) ? {sub_bit, 7'b000_0001} : {sub_bit, 7'b000_1001};
    else if (state_q == RUN || state_q == DRAIN)
      tag_d = 8'b0000_1000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      zero_q  <= 1'b0;
      for (int i = 0; i < OP_SKEW; i++) tag_q[i] <= 8'h00;
      a_q     <= '0;
      b_q     <= '0;
      opm_q   <= 8'h00;
      ce_q    <= 1'b0;
      rst_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
`ifdef DSP48A1_MAC_CTRL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      a_q      <= accept ? a_in : 18'd0;
      b_q      <= accept ? b_in : 18'd0;
      tag_q[0] <= tag_d;
      for (int i = 1; i < OP_SKEW; i++) tag_q[i] <= tag_q[i-1];
      opm_q    <= tag_q[OP_SKEW-1];
      rv_q     <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          len_q  <= len;
          cnt_q  <= '0;
          busy_q <= 1'b1;
`ifdef DSP48A1_MAC_CTRL_SUB_EN
          sub_q  <= sub;
`endif
          if (len == '0) begin
            zero_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            zero_q  <= 1'b0;
            rst_q   <= 1'b1;
            state_q <= CLR;
          end
        end
        CLR: begin
          rst_q   <= 1'b0;
          ce_q    <= 1'b1;
          rdy_q   <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (accept) begin
          cnt_q <= cnt_q + LEN_W'(1);
          if (last) begin
            rdy_q   <= 1'b0;
            drn_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // ce drops on the edge that completes the last P update
          if (drn_q == DW'(PIPE_LAT - 1)) begin
            ce_q    <= 1'b0;
            state_q <= DONE;
          end else begin
            drn_q <= drn_q + DW'(1);
          end
        end
        DONE: begin
          res_q   <= zero_q ? 48'd0 : dsp_P;
          rv_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = rdy_q;
  assign dsp_A        = a_q;
  assign dsp_B        = b_q;
  assign dsp_opmode   = opm_q;
  assign dsp_ce       = ce_q;
  assign dsp_rst      = rst_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// tb/tb_dsp48a1_mac_ctrl.sv - directed bench with slice model and per-cycle expected timeline
module tb_dsp48a1_mac_ctrl;

  localparam int PIPE_LAT = 3;
  localparam int OP_SKEW  = 1;
  localparam int DEPTH    = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] a_in = 18'd0, b_in = 18'd0;
  logic [17:0] dsp_A, dsp_B;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst;
  logic [47:0] dsp_P;
  logic [47:0] result;
  logic        result_valid, busy;
`ifdef DSP48A1_MAC_CTRL_SUB_EN
  logic        sub = 1'b0;
`endif

  dsp48a1_mac_ctrl #(.LEN_W(8), .PIPE_LAT(PIPE_LAT), .OP_SKEW(OP_SKEW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
`ifdef DSP48A1_MAC_CTRL_SUB_EN
    .sub(sub),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
    .dsp_rst(dsp_rst), .dsp_P(dsp_P), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural DSP48A1 slice: A1/B1 -> M -> P, OPMODEREG, sync reset over CE.
  logic signed [17:0] s_a1 = '0, s_b1 = '0;
  logic signed [35:0] s_m = '0;
  logic [7:0]         s_opm = '0;
  logic [47:0]        s_p = '0;
  logic [47:0]        s_x, s_z;
  assign s_x   = (s_opm[1:0] == 2'b01) ? {{12{s_m[35]}}, s_m} : 48'd0;
  assign s_z   = (s_opm[3:2] == 2'b10) ? s_p : 48'd0;
  assign dsp_P = s_p;
  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
    end else if (dsp_ce) begin
      s_a1  <= dsp_A;
      s_b1  <= dsp_B;
      s_m   <= s_a1 * s_b1;
      s_opm <= dsp_opmode;
      s_p   <= s_opm[7] ? s_z - s_x : s_z + s_x;
    end
  end

  typedef struct {
    logic        busy, ce, rst, rdy, rv;
    logic [17:0] a, b;
    logic [7:0]  tag;
    logic [47:0] res;
  } exp_t;

  exp_t        ex [DEPTH];
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0;
  logic [47:0] mres = '0;
  logic [17:0] pa [8], pb [8];
  int          pg [8];
  bit          psub = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exv);
    end
  endtask

  // Entry t holds what the outputs must be after rising edge number t.
  always @(negedge clk) begin
    if (!rst_n) mres = '0;
    else if (cyc >= OP_SKEW && cyc < DEPTH) begin
      if (ex[cyc].rv) mres = ex[cyc].res;
      chk("busy",         48'(busy),         48'(ex[cyc].busy));
      chk("dsp_ce",       48'(dsp_ce),       48'(ex[cyc].ce));
      chk("dsp_rst",      48'(dsp_rst),      48'(ex[cyc].rst));
      chk("in_ready",     48'(in_ready),     48'(ex[cyc].rdy));
      chk("result_valid", 48'(result_valid), 48'(ex[cyc].rv));
      chk("dsp_A",        48'(dsp_A),        48'(ex[cyc].a));
      chk("dsp_B",        48'(dsp_B),        48'(ex[cyc].b));
      chk("dsp_opmode",   48'(dsp_opmode),   48'(ex[cyc-OP_SKEW].tag));
      chk("result",       result,            mres);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int n, input int np, input bit abort, input bit glitch);
    int     t;
    longint sum, prod;
    logic [7:0] tg;
    t = cyc + 1;
    start = 1'b1;
    len = 8'(n);
`ifdef DSP48A1_MAC_CTRL_SUB_EN
    sub = psub;
`endif
    tick();
    start = 1'b0;
    ex[t].busy = 1'b1;
    if (n == 0) begin
      ex[t+1].rv  = 1'b1;
      ex[t+1].res = 48'd0;
      tick(); tick();
      return;
    end
    ex[t].rst = 1'b1;
    tick();
    t = cyc;
    ex[t].busy = 1'b1; ex[t].rdy = 1'b1; ex[t].ce = 1'b1;
    sum = 0;
    for (int k = 0; k < np; k++) begin
      for (int g = 0; g < pg[k]; g++) begin
        in_valid = 1'b0;
        tick();
        t = cyc;
        ex[t].busy = 1'b1; ex[t].rdy = 1'b1; ex[t].ce = 1'b1; ex[t].tag = 8'h08;
      end
      in_valid = 1'b1; a_in = pa[k]; b_in = pb[k];
      if (glitch && k == 0) begin start = 1'b1; len = 8'd9; end
      tick();
      t = cyc;
      in_valid = 1'b0; start = 1'b0; len = 8'(n); a_in = '0; b_in = '0;
      tg = (k == 0) ? 8'h01 : 8'h09;
      if (psub) tg[7] = 1'b1;
      ex[t].busy = 1'b1; ex[t].ce = 1'b1; ex[t].rdy = (k != n - 1);
      ex[t].a = pa[k]; ex[t].b = pb[k]; ex[t].tag = tg;
      prod = longint'($signed(pa[k])) * longint'($signed(pb[k]));
      sum  = psub ? sum - prod : sum + prod;
    end
    if (abort) begin
      @(negedge clk);
      #1 rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      return;
    end
    for (int d = 1; d <= PIPE_LAT; d++) begin
      ex[t+d].busy = 1'b1;
      ex[t+d].ce   = (d < PIPE_LAT);
      ex[t+d].tag  = 8'h08;
    end
    ex[t+PIPE_LAT+1].rv  = 1'b1;
    ex[t+PIPE_LAT+1].res = sum[47:0];
    repeat (PIPE_LAT + 2) tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ex[i] = '{default: '0};
    for (int i = 0; i < 8; i++) begin pa[i] = '0; pb[i] = '0; pg[i] = 0; end
    tick(); tick();
    chk("rst_busy",     48'(busy),         48'd0);
    chk("rst_in_ready", 48'(in_ready),     48'd0);
    chk("rst_ce",       48'(dsp_ce),       48'd0);
    chk("rst_rv",       48'(result_valid), 48'd0);
    chk("rst_opmode",   48'(dsp_opmode),   48'd0);
    chk("rst_result",   result,            48'd0);
    rst_n = 1'b1;
    tick(); tick();

    pa[0] = 18'd2; pb[0] = 18'd3; pa[1] = 18'd4; pb[1] = 18'd5; pa[2] = 18'd6; pb[2] = 18'd7;
    run_op(3, 3, 1'b0, 1'b0);
    chk("lit_dot3", result, 48'd68);
    tick(); tick();

    pa[0] = 18'd10; pb[0] = 18'd10; pg[1] = 5; pa[1] = 18'h3FFFF; pb[1] = 18'd3;
    run_op(2, 2, 1'b0, 1'b0);
    chk("lit_stall", result, 48'd97);
    pg[1] = 0;
    tick(); tick();

    run_op(0, 0, 1'b0, 1'b0);
    chk("lit_len0", result, 48'd0);
    tick();

    pa[0] = 18'd1; pb[0] = 18'd2; pa[1] = 18'd3; pb[1] = 18'd4;
    run_op(4, 2, 1'b1, 1'b0);
    chk("lit_abort_cleared", result, 48'd0);
    tick();
    pa[0] = 18'd5; pb[0] = 18'd5;
    run_op(1, 1, 1'b0, 1'b0);
    chk("lit_after_reset", result, 48'd25);
    tick();

    pa[0] = 18'd1; pb[0] = 18'd1; pa[1] = 18'd1; pb[1] = 18'd1;
    run_op(2, 2, 1'b0, 1'b1);
    chk("lit_start_ignored", result, 48'd2);
    tick(); tick();

`ifdef DSP48A1_MAC_CTRL_SUB_EN
    psub = 1'b1;
    pa[0] = 18'd3; pb[0] = 18'd4; pa[1] = 18'd1; pb[1] = 18'd2;
    run_op(2, 2, 1'b0, 1'b0);
    chk("lit_sub", result, 48'hFFFF_FFFF_FFF2);
    psub = 1'b0;
    tick(); tick();
`endif

    chk("hold_result", result, 48'(mres));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
